// File: rtl/crc_pkg.sv
// Shared types, CRC presets and helpers for the parametrised CRC engine.
package crc_pkg;

  typedef enum logic {IDLE, BUSY} state_t;

  // CRC-8 (SMBus flavour)
  localparam int        CRC8_W      = 8;
  localparam logic [7:0] CRC8_POLY  = 8'h07;
  localparam logic [7:0] CRC8_INIT  = 8'h00;
  localparam logic [7:0] CRC8_XOR   = 8'h00;
  localparam bit        CRC8_REFIN  = 1'b0;
  localparam bit        CRC8_REFOUT = 1'b0;

  // CRC-16-CCITT (FALSE variant)
  localparam int         CRC16_W      = 16;
  localparam logic [15:0] CRC16_POLY  = 16'h1021;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_XOR   = 16'h0000;
  localparam bit         CRC16_REFIN  = 1'b0;
  localparam bit         CRC16_REFOUT = 1'b0;

  // CRC-32 (Ethernet / zlib)
  localparam int         CRC32_W      = 32;
  localparam logic [31:0] CRC32_POLY  = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT  = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOR   = 32'hFFFFFFFF;
  localparam bit         CRC32_REFIN  = 1'b1;
  localparam bit         CRC32_REFOUT = 1'b1;

  // Reverses the low w bits of v; the result is right-aligned, upper bits zero
  // as long as the bits of v above w are zero.
  function automatic logic [63:0] bit_reverse(input logic [63:0] v, input logic [6:0] w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      r[i] = v[63-i];
    end
    return r >> (7'd64 - w);
  endfunction

endpackage

// File: rtl/crc_if.sv
// Framed input stream and result handshake between source, CRC engine and packetiser.
interface crc_if #(
  parameter int DATA_W = 8,
  parameter int CRC_W  = 8,
  parameter int LEN_W  = 16
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              s_first;
  logic              s_last;
  logic [CRC_W-1:0]  crc_out;
  logic [LEN_W-1:0]  crc_len;
  logic              crc_valid;
  logic              crc_ready;
  logic              restart;

  modport slave (
    input  s_data, s_valid, s_first, s_last, crc_ready,
    output s_ready, crc_out, crc_len, crc_valid, restart
  );

  modport master (
    output s_data, s_valid, s_first, s_last, crc_ready,
    input  s_ready, crc_out, crc_len, crc_valid, restart
  );
endinterface

// File: rtl/crc_step.sv
// Combinational fold of one DATA_W-bit beat into a CRC_W-bit LFSR state,
// i.e. DATA_W serial shift steps unrolled into a single cycle.
module crc_step #(
  parameter int               CRC_W  = 8,
  parameter int               DATA_W = 8,
  parameter logic [CRC_W-1:0] POLY   = 8'h07,
  parameter bit               REFIN  = 1'b0
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_out
);

  logic [CRC_W-1:0] stage [DATA_W+1];

  assign stage[0] = crc_in;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_step
    // REFIN feeds the beat LSB first, otherwise MSB first.
    localparam int BI = REFIN ? gi : DATA_W - 1 - gi;
    logic fb;
    assign fb           = stage[gi][CRC_W-1] ^ data[BI];
    assign stage[gi+1]  = {stage[gi][CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  assign crc_out = stage[DATA_W];

endmodule

// File: rtl/crc_engine.sv
// Word-parallel CRC engine: frames beats from the input stream, folds each beat
// into the running CRC and hands the final CRC plus beat count downstream.
module crc_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 8,
  parameter int               DATA_W  = 8,
  parameter logic [CRC_W-1:0] POLY    = 8'h07,
  parameter logic [CRC_W-1:0] INIT    = 8'h00,
  parameter logic [CRC_W-1:0] XOR_OUT = 8'h00,
  parameter bit               REFIN   = 1'b0,
  parameter bit               REFOUT  = 1'b0,
  parameter int               LEN_W   = 16
) (
  input  logic clk,
  input  logic rst,
  crc_if.slave bus
);

  state_t            state, state_next;
  logic [CRC_W-1:0]  crc_reg, seed, fold, crc_rev, result;
  logic [LEN_W-1:0]  cnt_reg, cnt_next;
  logic [CRC_W-1:0]  out_crc_reg;
  logic [LEN_W-1:0]  out_len_reg;
  logic              valid_reg, restart_reg;
  logic              accept, frame_start, restart_next;

  // Input stalls only while a result is pending and not being taken this cycle.
  assign bus.s_ready   = !valid_reg || bus.crc_ready;
  assign bus.crc_out   = out_crc_reg;
  assign bus.crc_len   = out_len_reg;
  assign bus.crc_valid = valid_reg;
  assign bus.restart   = restart_reg;

  assign accept = bus.s_valid && bus.s_ready;

  always_comb begin
    state_next   = state;
    frame_start  = (state == IDLE) || bus.s_first;
    restart_next = 1'b0;
    if (accept) begin
      restart_next = (state == BUSY) && bus.s_first;
      state_next   = bus.s_last ? IDLE : BUSY;
    end
  end

  // A new frame always folds into INIT, never into the abandoned running value.
  assign seed     = frame_start ? INIT : crc_reg;
  assign cnt_next = frame_start ? LEN_W'(1) : ((&cnt_reg) ? cnt_reg : cnt_reg + 1'b1);

  crc_step #(
    .CRC_W  (CRC_W),
    .DATA_W (DATA_W),
    .POLY   (POLY),
    .REFIN  (REFIN)
  ) u_step (
    .crc_in  (seed),
    .data    (bus.s_data),
    .crc_out (fold)
  );

  assign crc_rev = CRC_W'(bit_reverse(64'(fold), 7'(CRC_W)));
  assign result  = (REFOUT ? crc_rev : fold) ^ XOR_OUT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      crc_reg     <= INIT;
      cnt_reg     <= '0;
      out_crc_reg <= '0;
      out_len_reg <= '0;
      valid_reg   <= 1'b0;
      restart_reg <= 1'b0;
    end else begin
      state       <= state_next;
      restart_reg <= restart_next;
      if (accept) begin
        crc_reg <= bus.s_last ? INIT : fold;
        cnt_reg <= bus.s_last ? '0 : cnt_next;
      end
      // A last beat accepted in the same cycle as the old result keeps valid high.
      if (accept && bus.s_last) begin
        out_crc_reg <= result;
        out_len_reg <= cnt_next;
        valid_reg   <= 1'b1;
      end else if (bus.crc_ready) begin
        valid_reg   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench for crc_engine: a default CRC-8 instance and a CRC-32 instance.
module tb_crc_engine;
  import crc_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  crc_if #(.DATA_W(8), .CRC_W(8),  .LEN_W(16)) b8 ();
  crc_if #(.DATA_W(8), .CRC_W(32), .LEN_W(16)) b32 ();

  crc_engine dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  crc_engine #(
    .CRC_W   (CRC32_W),
    .DATA_W  (8),
    .POLY    (CRC32_POLY),
    .INIT    (CRC32_INIT),
    .XOR_OUT (CRC32_XOR),
    .REFIN   (CRC32_REFIN),
    .REFOUT  (CRC32_REFOUT),
    .LEN_W   (16)
  ) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One beat on the selected engine, waiting (bounded) for s_ready; returns at
  // the falling edge after the accepting rising edge.
  task automatic beat(input bit sel, input logic [7:0] d, input bit f, input bit l);
    int waited;
    waited = 0;
    if (sel) begin
      b32.s_data = d; b32.s_first = f; b32.s_last = l; b32.s_valid = 1'b1;
    end else begin
      b8.s_data = d; b8.s_first = f; b8.s_last = l; b8.s_valid = 1'b1;
    end
    while (!(sel ? b32.s_ready : b8.s_ready) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (waited >= 50) begin
      miscompares++;
      $display("FAIL beat_accept: s_ready stayed 0 for %0d cycles, required 1", waited);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    if (sel) begin
      b32.s_valid = 1'b0; b32.s_first = 1'b0; b32.s_last = 1'b0;
    end else begin
      b8.s_valid = 1'b0; b8.s_first = 1'b0; b8.s_last = 1'b0;
    end
  endtask

  task automatic send_str(input bit sel, input string s, input bit f, input bit l);
    for (int i = 0; i < s.len(); i++) begin
      beat(sel, s[i], f && (i == 0), l && (i == s.len() - 1));
    end
  endtask

  task automatic test_reset;
    vectors++;
    if (b8.crc_valid !== 1'b0 || b8.crc_out !== 8'h00 || b8.crc_len !== 16'd0 || b8.restart !== 1'b0) begin
      miscompares++;
      $display("FAIL reset8: valid=%b out=%h len=%0d restart=%b, required 0/00/0/0",
               b8.crc_valid, b8.crc_out, b8.crc_len, b8.restart);
    end
    vectors++;
    if (b8.s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: s_ready=%b, required 1", b8.s_ready);
    end
    vectors++;
    if (b32.crc_valid !== 1'b0 || b32.crc_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset32: valid=%b out=%h, required 0/00000000", b32.crc_valid, b32.crc_out);
    end
  endtask

  task automatic test_check_value;
    send_str(1'b0, "123456789", 1'b1, 1'b1);
    vectors++;
    if (b8.crc_valid !== 1'b1 || b8.crc_out !== 8'hF4 || b8.crc_len !== 16'd9) begin
      miscompares++;
      $display("FAIL crc8_check: valid=%b out=%h len=%0d, required 1/f4/9",
               b8.crc_valid, b8.crc_out, b8.crc_len);
    end
    @(negedge clk);
    vectors++;
    if (b8.crc_valid !== 1'b0 || b8.crc_out !== 8'hF4) begin
      miscompares++;
      $display("FAIL crc8_consume: valid=%b out=%h, required 0/f4", b8.crc_valid, b8.crc_out);
    end
  endtask

  task automatic test_single_beat;
    beat(1'b0, 8'h01, 1'b1, 1'b1);
    vectors++;
    if (b8.crc_valid !== 1'b1 || b8.crc_out !== 8'h07 || b8.crc_len !== 16'd1) begin
      miscompares++;
      $display("FAIL single_01: valid=%b out=%h len=%0d, required 1/07/1",
               b8.crc_valid, b8.crc_out, b8.crc_len);
    end
    beat(1'b0, 8'h00, 1'b1, 1'b1);
    vectors++;
    if (b8.crc_valid !== 1'b1 || b8.crc_out !== 8'h00 || b8.crc_len !== 16'd1) begin
      miscompares++;
      $display("FAIL single_00: valid=%b out=%h len=%0d, required 1/00/1",
               b8.crc_valid, b8.crc_out, b8.crc_len);
    end
    @(negedge clk);
  endtask

  task automatic test_crc32;
    send_str(1'b1, "123456789", 1'b1, 1'b1);
    vectors++;
    if (b32.crc_valid !== 1'b1 || b32.crc_out !== 32'hCBF43926 || b32.crc_len !== 16'd9) begin
      miscompares++;
      $display("FAIL crc32_check: valid=%b out=%h len=%0d, required 1/cbf43926/9",
               b32.crc_valid, b32.crc_out, b32.crc_len);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    b8.crc_ready = 1'b0;
    send_str(1'b0, "123456789", 1'b1, 1'b1);
    b8.s_data = 8'h01; b8.s_first = 1'b1; b8.s_last = 1'b1; b8.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (b8.s_ready !== 1'b0 || b8.crc_valid !== 1'b1 || b8.crc_out !== 8'hF4 || b8.crc_len !== 16'd9) begin
        miscompares++;
        $display("FAIL stall_hold: ready=%b valid=%b out=%h len=%0d, required 0/1/f4/9",
                 b8.s_ready, b8.crc_valid, b8.crc_out, b8.crc_len);
      end
    end
    b8.crc_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b8.s_valid = 1'b0; b8.s_first = 1'b0; b8.s_last = 1'b0;
    vectors++;
    if (b8.crc_valid !== 1'b1 || b8.crc_out !== 8'h07 || b8.crc_len !== 16'd1) begin
      miscompares++;
      $display("FAIL back_to_back: valid=%b out=%h len=%0d, required 1/07/1",
               b8.crc_valid, b8.crc_out, b8.crc_len);
    end
    @(negedge clk);
    vectors++;
    if (b8.crc_valid !== 1'b0 || b8.crc_out !== 8'h07 || b8.crc_len !== 16'd1) begin
      miscompares++;
      $display("FAIL hold_after_valid: valid=%b out=%h len=%0d, required 0/07/1",
               b8.crc_valid, b8.crc_out, b8.crc_len);
    end
  endtask

  task automatic test_restart;
    string s;
    int    pulses;
    pulses = 0;
    s = "12123456789";
    for (int i = 0; i < s.len(); i++) begin
      beat(1'b0, s[i], (i == 0) || (i == 2), i == s.len() - 1);
      if (b8.restart === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL restart_pulses: got %0d pulses, required 1", pulses);
    end
    vectors++;
    if (b8.crc_valid !== 1'b1 || b8.crc_out !== 8'hF4 || b8.crc_len !== 16'd9) begin
      miscompares++;
      $display("FAIL restart_crc: valid=%b out=%h len=%0d, required 1/f4/9",
               b8.crc_valid, b8.crc_out, b8.crc_len);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    send_str(1'b0, "1234", 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (b8.crc_valid !== 1'b0 || b8.crc_out !== 8'h00 || b8.crc_len !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_mid_frame: valid=%b out=%h len=%0d, required 0/00/0",
               b8.crc_valid, b8.crc_out, b8.crc_len);
    end
    send_str(1'b0, "123456789", 1'b1, 1'b1);
    vectors++;
    if (b8.crc_valid !== 1'b1 || b8.crc_out !== 8'hF4 || b8.crc_len !== 16'd9) begin
      miscompares++;
      $display("FAIL after_rst_frame: valid=%b out=%h len=%0d, required 1/f4/9",
               b8.crc_valid, b8.crc_out, b8.crc_len);
    end
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    b8.s_data = '0;  b8.s_valid = 1'b0;  b8.s_first = 1'b0;  b8.s_last = 1'b0;  b8.crc_ready = 1'b1;
    b32.s_data = '0; b32.s_valid = 1'b0; b32.s_first = 1'b0; b32.s_last = 1'b0; b32.crc_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    test_reset();
    test_check_value();
    test_single_beat();
    test_crc32();
    test_backpressure();
    test_restart();
    test_reset_mid_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
